// File: rtl/ustc_pkg.sv
// Shared definitions for the unstructured-sparse tile controller:
// FSM encoding, ctrl-field layout and tile-count helper.
package ustc_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_TURN   = 3'd2,
    ST_FLUSH1 = 3'd3,
    ST_FLUSH2 = 3'd4,
    ST_OUT    = 3'd5
  } state_e;

  localparam int DW_CTRL        = 4;
  localparam int CTRL_VALID_BIT = DW_CTRL - 2;

  function automatic int calc_nt(input int n, input int tile_n);
    return n / tile_n;
  endfunction

endpackage

// File: rtl/ustc_tile_counter.sv
// Beat and tile counters for the partial-sum sequencer; flags the last
// beat of a tile and the last tile of a command.
module ustc_tile_counter
  import ustc_pkg::*;
#(
  parameter int NT      = 4,
  parameter int DW_KCNT = 8,
  parameter int DW_T    = 2
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               load,
  input  logic [DW_KCNT-1:0] k_steps,
  input  logic               beat,
  input  logic               b_clr,
  input  logic               t_adv,
  output logic [DW_T-1:0]    t_nxt,
  output logic               last_beat,
  output logic               last_tile
);

  localparam logic [DW_KCNT-1:0] K_ONE  = DW_KCNT'(1);
  localparam logic [DW_KCNT-1:0] K_ZERO = DW_KCNT'(0);
  localparam logic [DW_T-1:0]    T_ONE  = DW_T'(1);
  localparam logic [DW_T-1:0]    T_ZERO = DW_T'(0);
  localparam logic [DW_T-1:0]    T_LAST = DW_T'(NT - 1);

  logic [DW_KCNT-1:0] b_r;
  logic [DW_KCNT-1:0] kq_r;
  logic [DW_KCNT-1:0] b_nxt_s;
  logic [DW_T-1:0]    t_r;

  // next beat and tile index
  always_comb begin
    b_nxt_s = b_r;
    t_nxt   = t_r;
    if (load) begin
      b_nxt_s = K_ZERO;
      t_nxt   = T_ZERO;
    end else begin
      if (b_clr) begin
        b_nxt_s = K_ZERO;
      end else if (beat) begin
        b_nxt_s = b_r + K_ONE;
      end else begin
        b_nxt_s = b_r;
      end
      if (t_adv) begin
        t_nxt = t_r + T_ONE;
      end else begin
        t_nxt = t_r;
      end
    end
  end

  // counter and latched beat-count registers
  always_ff @(posedge clk) begin
    if (rst) begin
      b_r  <= K_ZERO;
      t_r  <= T_ZERO;
      kq_r <= K_ZERO;
    end else begin
      b_r  <= b_nxt_s;
      t_r  <= t_nxt;
      kq_r <= load ? k_steps : kq_r;
    end
  end

  assign last_beat = (b_r == (kq_r - K_ONE));
  assign last_tile = (t_r == T_LAST);

endmodule

// File: rtl/ustc_psum_ctrl.sv
// Sequencer for the sparse partial-sum accumulator: walks column tiles,
// inserts the commit bubble between tiles, flushes, then hands off the result.
module ustc_psum_ctrl
  import ustc_pkg::*;
#(
  parameter int N       = 16,
  parameter int TILE_N  = 4,
  parameter int DW_POS  = 4,
  parameter int DW_KCNT = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [DW_KCNT-1:0] k_steps,
  output logic               busy,
  output logic               done,
  input  logic               in_valid,
  output logic               in_ready,
  output logic [DW_POS-1:0]  col,
  output logic               input_en,
  output logic               out_en,
  input  logic               out_ready
);

  localparam int NT   = calc_nt(N, TILE_N);
  localparam int DW_T = $clog2(NT);

  if ((N < 2 * TILE_N) || ((N % TILE_N) != 0) || ((N - TILE_N) >= (2 ** DW_POS))) begin : g_bad_cfg
    $error("ustc_psum_ctrl: illegal N/TILE_N/DW_POS combination");
  end

  state_e              state_r;
  state_e              state_nxt_s;
  logic [DW_T-1:0]     t_nxt_s;
  logic                last_beat_s;
  logic                last_tile_s;
  logic                load_s;
  logic                beat_s;
  logic                t_adv_s;
  logic                b_clr_s;
  logic                busy_r;
  logic                in_ready_r;
  logic                input_en_r;
  logic                out_en_r;
  logic [DW_POS-1:0]   col_r;
  logic [DW_POS-1:0]   col_nxt_s;

  assign beat_s = in_valid & in_ready_r;

  ustc_tile_counter #(
    .NT      (NT),
    .DW_KCNT (DW_KCNT),
    .DW_T    (DW_T)
  ) u_cnt (
    .clk       (clk),
    .rst       (rst),
    .load      (load_s),
    .k_steps   (k_steps),
    .beat      (beat_s),
    .b_clr     (b_clr_s),
    .t_adv     (t_adv_s),
    .t_nxt     (t_nxt_s),
    .last_beat (last_beat_s),
    .last_tile (last_tile_s)
  );

  // next-state and counter control
  always_comb begin
    state_nxt_s = state_r;
    load_s      = 1'b0;
    t_adv_s     = 1'b0;
    b_clr_s     = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (start && (k_steps != {DW_KCNT{1'b0}})) begin
          load_s      = 1'b1;
          state_nxt_s = ST_RUN;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (beat_s && last_beat_s) begin
          if (last_tile_s) begin
            state_nxt_s = ST_FLUSH1;
          end else begin
            t_adv_s     = 1'b1;
            state_nxt_s = ST_TURN;
          end
        end else begin
          state_nxt_s = ST_RUN;
        end
      end
      ST_TURN: begin
        b_clr_s     = 1'b1;
        state_nxt_s = ST_RUN;
      end
      ST_FLUSH1: state_nxt_s = ST_FLUSH2;
      ST_FLUSH2: state_nxt_s = ST_OUT;
      ST_OUT: begin
        if (out_ready) begin
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_OUT;
        end
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // column presented in the upcoming state; zero while idle or flushing
  always_comb begin
    col_nxt_s = {DW_POS{1'b0}};
    case (state_nxt_s)
      ST_RUN, ST_TURN, ST_OUT: col_nxt_s = DW_POS'(t_nxt_s) * DW_POS'(TILE_N);
      default:                 col_nxt_s = {DW_POS{1'b0}};
    endcase
  end

  // state and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      busy_r     <= 1'b0;
      in_ready_r <= 1'b0;
      input_en_r <= 1'b0;
      out_en_r   <= 1'b0;
      col_r      <= {DW_POS{1'b0}};
    end else begin
      state_r    <= state_nxt_s;
      busy_r     <= (state_nxt_s != ST_IDLE);
      in_ready_r <= (state_nxt_s == ST_RUN);
      input_en_r <= (state_nxt_s == ST_RUN) || (state_nxt_s == ST_TURN);
      out_en_r   <= (state_nxt_s == ST_OUT);
      col_r      <= col_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign in_ready = in_ready_r;
  assign input_en = input_en_r;
  assign out_en   = out_en_r;
  assign col      = col_r;
  // done tracks out_ready in the same cycle so the handshake closes at once
  assign done     = out_en_r & out_ready;

endmodule

// File: tb/tb_ustc_psum_ctrl.sv
// Randomized bench for ustc_psum_ctrl against a per-cycle expectation list
// built from tile/beat loops.
module tb_ustc_psum_ctrl;

  localparam int N       = 16;
  localparam int TILE_N  = 4;
  localparam int DW_POS  = 4;
  localparam int DW_KCNT = 8;
  localparam int NT      = N / TILE_N;

  logic               clk;
  logic               rst;
  logic               start;
  logic [DW_KCNT-1:0] k_steps;
  logic               busy;
  logic               done;
  logic               in_valid;
  logic               in_ready;
  logic [DW_POS-1:0]  col;
  logic               input_en;
  logic               out_en;
  logic               out_ready;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic       iv;
    logic       ordy;
    logic       st;
    logic [7:0] k;
    logic [3:0] col;
    logic       ir;
    logic       ie;
    logic       bz;
    logic       oe;
    logic       dn;
    logic       turn;
  } cyc_t;

  cyc_t exp_q[$];
  int   nstall;

  ustc_psum_ctrl #(
    .N       (N),
    .TILE_N  (TILE_N),
    .DW_POS  (DW_POS),
    .DW_KCNT (DW_KCNT)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .k_steps   (k_steps),
    .busy      (busy),
    .done      (done),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .col       (col),
    .input_en  (input_en),
    .out_en    (out_en),
    .out_ready (out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h at %0t", tag, got, want, $time);
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  task automatic push(input logic iv, input logic ordy, input int c, input logic ir,
                      input logic ie, input logic bz, input logic oe, input logic dn,
                      input logic turn);
    cyc_t e;
    e.iv   = iv;
    e.ordy = ordy;
    e.st   = bz ? ($urandom_range(0, 3) == 0) : 1'b0;
    e.k    = 8'($urandom_range(0, 255));
    e.col  = 4'(c);
    e.ir   = ir;
    e.ie   = ie;
    e.bz   = bz;
    e.oe   = oe;
    e.dn   = dn;
    e.turn = turn;
    exp_q.push_back(e);
  endtask

  // expected cycle list for one command, from cycle 1 after the start
  task automatic build_cmd(input int kq, input int stall_pct, input int wait_out);
    exp_q.delete();
    nstall = 0;
    for (int t = 0; t < NT; t++) begin
      for (int b = 0; b < kq; b++) begin
        for (int s = 0; s < 4 && $urandom_range(0, 99) < stall_pct; s++) begin
          push(1'b0, rnd(), t * TILE_N, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
          nstall++;
        end
        push(1'b1, rnd(), t * TILE_N, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      end
      if (t < NT - 1) push(rnd(), rnd(), (t + 1) * TILE_N, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    end
    for (int f = 0; f < 2; f++) push(rnd(), rnd(), 0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    for (int w = 0; w < wait_out; w++)
      push(rnd(), 1'b0, (NT - 1) * TILE_N, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
    push(rnd(), 1'b1, (NT - 1) * TILE_N, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0);
    push(1'b0, 1'b0, 0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic check_reset(input string tag);
    check({tag, "_col"},  32'(col),      32'd0);
    check({tag, "_ir"},   32'(in_ready), 32'd0);
    check({tag, "_ie"},   32'(input_en), 32'd0);
    check({tag, "_busy"}, 32'(busy),     32'd0);
    check({tag, "_oe"},   32'(out_en),   32'd0);
    check({tag, "_done"}, 32'(done),     32'd0);
  endtask

  task automatic run_cmd(input int kq, input int stall_pct, input int wait_out, input bit abort);
    int first_oe;
    int n_done;
    build_cmd(kq, stall_pct, wait_out);
    first_oe = -1;
    n_done   = 0;
    @(negedge clk);
    start     = 1'b1;
    k_steps   = 8'(kq);
    in_valid  = rnd();
    out_ready = 1'b0;
    #1;
    check("pre_busy", 32'(busy), 32'd0);
    check("pre_ir",   32'(in_ready), 32'd0);
    for (int i = 0; i < exp_q.size(); i++) begin
      @(negedge clk);
      start     = exp_q[i].st;
      k_steps   = exp_q[i].k;
      in_valid  = exp_q[i].iv;
      out_ready = exp_q[i].ordy;
      #1;
      check("col",      32'(col),      32'(exp_q[i].col));
      check("in_ready", 32'(in_ready), 32'(exp_q[i].ir));
      check("input_en", 32'(input_en), 32'(exp_q[i].ie));
      check("busy",     32'(busy),     32'(exp_q[i].bz));
      check("out_en",   32'(out_en),   32'(exp_q[i].oe));
      check("done",     32'(done),     32'(exp_q[i].dn));
      if (out_en && first_oe < 0) first_oe = i + 1;
      if (done) n_done++;
      if (abort && exp_q[i].turn && exp_q[i].col == 4'd8) begin
        rst = 1'b1;
        @(negedge clk);
        rst       = 1'b0;
        start     = 1'b0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        check_reset("abort");
        return;
      end
    end
    check("oe_cycle", 32'(first_oe), 32'(1 + NT * kq + (NT - 1) + 2 + nstall));
    check("done_cnt", 32'(n_done), 32'd1);
  endtask

  initial begin
    rst       = 1'b1;
    start     = 1'b0;
    k_steps   = '0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    check_reset("rst");

    run_cmd(3, 0, 0, 1'b0);
    run_cmd(3, 30, 0, 1'b0);
    run_cmd(3, 0, 5, 1'b0);

    @(negedge clk);
    start   = 1'b1;
    k_steps = 8'd0;
    #1;
    @(negedge clk);
    start = 1'b0;
    #1;
    check_reset("kzero");
    @(negedge clk);
    #1;
    check_reset("kzero2");

    run_cmd(3, 0, 0, 1'b1);
    run_cmd(1, 0, 0, 1'b0);

    for (int r = 0; r < 8; r++) begin
      run_cmd($urandom_range(1, 6), $urandom_range(0, 40), $urandom_range(0, 4), 1'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
